// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: instruction-memory handshake, decode-side redirect/stall
// controls, IF/ID pipeline outputs and the performance counters.
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;

  logic        hazard;
  logic        branch;
  logic        jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        halt;

  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    input  ihit, imemload, hazard, branch, jump,
           branch_target, jump_target, halt,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid,
           stall_cnt, flush_cnt
  );

  modport slave (
    output ihit, imemload, hazard, branch, jump,
           branch_target, jump_target, halt,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/halt FSM and IF/ID latch.
// Optional saturating stall/flush counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fif
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    PEND_REDIR = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t              state_p0, state_nxt;
  logic [DATA_W-1:0]   pc_p0, pc_nxt;
  logic [DATA_W-1:0]   redir_pc_p0, redir_pc_nxt;
  logic [DATA_W-1:0]   ifid_instr_p1, ifid_instr_nxt;
  logic [DATA_W-1:0]   ifid_npc_p1, ifid_npc_nxt;
  logic                vld_p1, vld_nxt;

  logic                redirect;
  logic [DATA_W-1:0]   target;
  logic [DATA_W-1:0]   pc_plus4;

  assign redirect = fif.branch | fif.jump;
  // Word-align the target; jump wins when both redirects assert together.
  assign target   = (fif.jump ? fif.jump_target : fif.branch_target) & ~32'h3;
  assign pc_plus4 = pc_p0 + 32'd4;

  // Stage p0: PC / FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= FETCH;
      pc_p0       <= PC_INIT;
      redir_pc_p0 <= '0;
    end else begin
      state_p0    <= state_nxt;
      pc_p0       <= pc_nxt;
      redir_pc_p0 <= redir_pc_nxt;
    end
  end

  // Priority: HALTED > hazard > halt > redirect > normal fetch
  always_comb begin
    state_nxt      = state_p0;
    pc_nxt         = pc_p0;
    redir_pc_nxt   = redir_pc_p0;
    ifid_instr_nxt = ifid_instr_p1;
    ifid_npc_nxt   = ifid_npc_p1;
    vld_nxt        = vld_p1;

    if (state_p0 == HALTED) begin
      ifid_instr_nxt = '0;
      ifid_npc_nxt   = '0;
      vld_nxt        = 1'b0;
    end else if (fif.hazard) begin
      // Everything holds; the word returned this cycle is refetched later.
      state_nxt = state_p0;
    end else if (fif.halt) begin
      ifid_instr_nxt = '0;
      ifid_npc_nxt   = '0;
      vld_nxt        = 1'b0;
      state_nxt      = HALTED;
    end else if (redirect) begin
      ifid_instr_nxt = '0;
      ifid_npc_nxt   = '0;
      vld_nxt        = 1'b0;
      if (fif.ihit) begin
        pc_nxt    = target;
        state_nxt = FETCH;
      end else begin
        // Address must stay put until the outstanding request returns.
        redir_pc_nxt = target;
        state_nxt    = PEND_REDIR;
      end
    end else begin
      ifid_instr_nxt = '0;
      ifid_npc_nxt   = '0;
      vld_nxt        = 1'b0;
      unique case (state_p0)
        FETCH: begin
          if (fif.ihit) begin
            ifid_instr_nxt = fif.imemload;
            ifid_npc_nxt   = pc_plus4;
            vld_nxt        = 1'b1;
            pc_nxt         = pc_plus4;
          end
        end
        PEND_REDIR: begin
          if (fif.ihit) begin
            pc_nxt    = redir_pc_p0;
            state_nxt = FETCH;
          end
        end
        default: begin
          state_nxt = state_p0;
        end
      endcase
    end
  end

  // Stage p1: IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr_p1 <= '0;
      ifid_npc_p1   <= '0;
      vld_p1        <= 1'b0;
    end else begin
      ifid_instr_p1 <= ifid_instr_nxt;
      ifid_npc_p1   <= ifid_npc_nxt;
      vld_p1        <= vld_nxt;
    end
  end

  assign fif.imemREN    = (state_p0 != HALTED);
  assign fif.imemaddr   = pc_p0;
  assign fif.ifid_instr = ifid_instr_p1;
  assign fif.ifid_npc   = ifid_npc_p1;
  assign fif.ifid_valid = vld_p1;

`ifdef FETCH_PERF_EN
  logic              stall_ev, flush_ev;
  logic [DATA_W-1:0] stall_cnt_p1, flush_cnt_p1;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 32'd1;
  endfunction

  assign stall_ev = (state_p0 != HALTED) & fif.hazard;
  assign flush_ev = (state_p0 != HALTED) & ~fif.hazard & ~fif.halt & redirect;

  // Stage p1: performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else begin
      if (stall_ev) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush_ev) flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

  assign fif.stall_cnt = stall_cnt_p1;
  assign fif.flush_cnt = flush_cnt_p1;
`else
  assign fif.stall_cnt = '0;
  assign fif.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expectations queued per step, compared after each edge.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        ren;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic clk;
  logic rst;
  fetch_stage_if fif ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.master)
  );

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] c(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".imemaddr"},   fif.imemaddr,         e.addr);
    chk({e.tag, ".imemREN"},    {31'd0, fif.imemREN}, {31'd0, e.ren});
    chk({e.tag, ".ifid_valid"}, {31'd0, fif.ifid_valid}, {31'd0, e.vld});
    chk({e.tag, ".ifid_instr"}, fif.ifid_instr,       e.instr);
    chk({e.tag, ".ifid_npc"},   fif.ifid_npc,         e.npc);
    chk({e.tag, ".stall_cnt"},  fif.stall_cnt,        e.stall);
    chk({e.tag, ".flush_cnt"},  fif.flush_cnt,        e.flush);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then compare.
  task automatic step(input string tag,
                      input logic ihit, input logic [31:0] load,
                      input logic hz, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic hl,
                      input logic [31:0] e_addr, input logic e_ren, input logic e_vld,
                      input logic [31:0] e_instr, input logic [31:0] e_npc,
                      input int e_stall, input int e_flush);
    exp_t e;
    fif.ihit = ihit;  fif.imemload = load;
    fif.hazard = hz;  fif.branch = br;  fif.branch_target = bt;
    fif.jump = jp;    fif.jump_target = jt;  fif.halt = hl;
    e.tag = tag; e.addr = e_addr; e.ren = e_ren; e.vld = e_vld;
    e.instr = e_instr; e.npc = e_npc; e.stall = c(e_stall); e.flush = c(e_flush);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
    end else begin
      chk_all(sb.pop_front());
    end
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".imemaddr"},   fif.imemaddr, 32'h0);
    chk({tag, ".imemREN"},    {31'd0, fif.imemREN}, 32'd1);
    chk({tag, ".ifid_valid"}, {31'd0, fif.ifid_valid}, 32'd0);
    chk({tag, ".ifid_instr"}, fif.ifid_instr, 32'h0);
    chk({tag, ".ifid_npc"},   fif.ifid_npc, 32'h0);
    chk({tag, ".stall_cnt"},  fif.stall_cnt, 32'h0);
    chk({tag, ".flush_cnt"},  fif.flush_cnt, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fif.ihit = 1'b0; fif.imemload = '0; fif.hazard = 1'b0;
    fif.branch = 1'b0; fif.branch_target = '0;
    fif.jump = 1'b0; fif.jump_target = '0; fif.halt = 1'b0;
    #2;
    async_reset_check("reset");
    #1;

    // Sequential fetch from PC_INIT
    step("fetch0", 1, 32'h20010005, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 32'h20010005, 32'h4, 0, 0);
    step("fetch1", 1, 32'h20010005, 0, 0, 0, 0, 0, 0, 32'h8, 1, 1, 32'h20010005, 32'h8, 0, 0);
    step("fetch2", 1, 32'h20010005, 0, 0, 0, 0, 0, 0, 32'hC, 1, 1, 32'h20010005, 32'hC, 0, 0);

    // Redirects on ihit; jump beats branch, low bits cleared
    step("jmp40",  1, 32'h1, 0, 0, 0,            1, 32'h40,  0, 32'h40,  1, 0, 0, 0, 0, 1);
    step("jmp103", 1, 32'h1, 0, 1, 32'h200,      1, 32'h103, 0, 32'h100, 1, 0, 0, 0, 0, 2);
    step("jmp40b", 1, 32'h1, 0, 0, 0,            1, 32'h40,  0, 32'h40,  1, 0, 0, 0, 0, 3);

    // Branch while the fetch is outstanding
    step("br_miss",   0, 32'h0,        0, 1, 32'h80, 0, 0, 0, 32'h40, 1, 0, 0, 0, 0, 4);
    step("pend_wait", 0, 32'h0,        0, 0, 0,      0, 0, 0, 32'h40, 1, 0, 0, 0, 0, 4);
    step("pend_hit",  1, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0, 32'h80, 1, 0, 0, 0, 0, 4);
    step("after_br",  1, 32'h11,       0, 0, 0,      0, 0, 0, 32'h84, 1, 1, 32'h11, 32'h84, 0, 4);

    // Newer redirects overwrite the pending target
    step("pend_a",    0, 32'h0,  0, 1, 32'h202, 0, 0,       0, 32'h84,  1, 0, 0, 0, 0, 5);
    step("pend_b",    0, 32'h0,  0, 0, 0,       1, 32'h301, 0, 32'h84,  1, 0, 0, 0, 0, 6);
    step("pend_done", 1, 32'h99, 0, 0, 0,       0, 0,       0, 32'h300, 1, 0, 0, 0, 0, 6);

    // Hazard holds PC and IF/ID, ignores branch
    step("jmp0c",  1, 32'h1,  0, 0, 0, 1, 32'hC, 0, 32'hC,  1, 0, 0, 0, 0, 7);
    step("fetchc", 1, 32'hAA, 0, 0, 0, 0, 0,     0, 32'h10, 1, 1, 32'hAA, 32'h10, 0, 7);
    for (int i = 1; i <= 3; i++)
      step("haz", 1, 32'hBB, 1, 1, 32'h80, 0, 0, 0, 32'h10, 1, 1, 32'hAA, 32'h10, i, 7);
    step("haz_rel_miss", 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0, 3, 7);

    // PC wrap, then halt beats a simultaneous jump
    step("jmpfffc",   1, 32'h1,  0, 0, 0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, 1, 0, 0, 0, 3, 8);
    step("wrap",      1, 32'h77, 0, 0, 0, 0, 0,            0, 32'h0, 1, 1, 32'h77, 32'h0, 3, 8);
    step("halt",      1, 32'h1,  0, 0, 0, 1, 32'h500,      1, 32'h0, 0, 0, 0, 0, 3, 8);
    step("halted",    1, 32'h55, 0, 0, 0, 0, 0,            0, 32'h0, 0, 0, 0, 0, 3, 8);
    step("halted_hz", 1, 32'h55, 1, 1, 32'h80, 0, 0,       0, 32'h0, 0, 0, 0, 0, 3, 8);

    // Reset recovers from HALTED and discards a pending redirect
    async_reset_check("rst_halted");
    step("jmp500miss", 0, 32'h0,   0, 0, 0, 1, 32'h500, 0, 32'h0, 1, 0, 0, 0, 0, 1);
    async_reset_check("rst_pend");
    step("post_rst",   1, 32'h123, 0, 0, 0, 0, 0,       0, 32'h4, 1, 1, 32'h123, 32'h4, 0, 0);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
